spi_cmd_bridge: RTL and testbench

- Command-decoding bridge between the byte-level SPI slave and the CPU core's 16-bit data ports.
- Generalised successor to the fixed SPI-to-CPU hookup: parametrised word width, buffered write FIFO, read-back holding register, status command and frame-abort handling.
- Consumes received bytes, assembles DATA_W words for the CPU, and supplies the next tx byte to the SPI slave.

---
 rtl/spi_cmd_bridge.sv | 196 +++++++++++++++++++
 tb/tb_spi_cmd_bridge.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_bridge.sv
// SPI command bridge: decodes WR/RD/ST frames from rx bytes into a write FIFO, read-back hold register and status byte.
// tx_byte and FIFO head update one cycle after the rx strobe; overflowing writes are dropped and flagged (no rx backpressure).
module spi_cmd_bridge #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_byte_ready,
    input  logic [7:0]        rx_byte,
    input  logic              cs_active,
    output logic [7:0]        tx_byte,
    output logic [DATA_W-1:0] cpu_in_data,
    output logic              cpu_in_valid,
    input  logic              cpu_in_ready,
    input  logic [DATA_W-1:0] cpu_out_data,
    input  logic              cpu_out_valid,
    output logic              cpu_out_ready,
    output logic              overflow
);

    localparam int          NB     = DATA_W / 8;
    localparam int          PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0]  NB4    = 4'(NB);
    localparam logic [3:0]  DEPTH4 = 4'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_ST,
        S_DISCARD
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]  asm_q, asm_d;
    logic [7:0]         tx_q, tx_d;
    logic               rd_ok_q, rd_ok_d;
    logic               ovf_q, ovf_d;
    logic [DATA_W-1:0]  hold_q;
    logic               hold_full_q;
    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [3:0]         fifo_cnt_q;

    logic               fifo_empty, fifo_full;
    logic               push_req, push, pop, drop;
    logic               hold_cap, hold_rel, ovf_clr;
    logic [DATA_W-1:0]  asm_shift;
    logic [7:0]         hold_byte;
    logic [7:0]         status;

    assign fifo_empty = (fifo_cnt_q == 4'd0);
    assign fifo_full  = (fifo_cnt_q == DEPTH4);
    assign pop        = !fifo_empty && cpu_in_ready;
    assign push       = push_req && (!fifo_full || pop);
    assign drop       = push_req && !push;
    assign hold_cap   = cpu_out_valid && !hold_full_q;
    assign asm_shift  = (asm_q << 8) | DATA_W'(rx_byte);
    assign status     = {ovf_q, hold_full_q, fifo_full, fifo_empty, fifo_cnt_q};

    assign tx_byte       = tx_q;
    assign cpu_in_valid  = !fifo_empty;
    assign cpu_in_data   = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign cpu_out_ready = !hold_full_q;
    assign overflow      = ovf_q;

    // Read-back byte selected by the byte counter, MSB byte first.
    always_comb begin
        hold_byte = 8'h00;
        for (int i = 0; i < NB; i++) begin
            if (cnt_q == 4'(i)) hold_byte = hold_q[DATA_W-1-8*i -: 8];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        tx_d     = tx_q;
        rd_ok_d  = rd_ok_q;
        push_req = 1'b0;
        hold_rel = 1'b0;
        ovf_clr  = 1'b0;
        if (!cs_active) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            asm_d   = '0;
            tx_d    = 8'h00;
            rd_ok_d = 1'b0;
        end else if (rx_byte_ready) begin
            tx_d = 8'h00;
            unique case (state_q)
                S_IDLE: begin
                    cnt_d = 4'd0;
                    unique case (rx_byte)
                        8'h01: state_d = S_WR;
                        8'h02: begin
                            state_d = S_RD;
                            rd_ok_d = hold_full_q;
                            cnt_d   = 4'd1;
                            if (hold_full_q) tx_d = hold_q[DATA_W-1 -: 8];
                        end
                        8'h03: begin
                            state_d = S_ST;
                            tx_d    = status;
                        end
                        default: state_d = S_DISCARD;
                    endcase
                end
                S_WR: begin
                    asm_d = asm_shift;
                    if (cnt_q == NB4 - 4'd1) begin
                        push_req = 1'b1;
                        cnt_d    = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_RD: begin
                    // cnt_q is the next byte to present; NB means the word has been fully shifted out.
                    if (rd_ok_q && hold_full_q) begin
                        if (cnt_q == NB4) begin
                            hold_rel = 1'b1;
                            cnt_d    = 4'd0;
                        end else begin
                            tx_d  = hold_byte;
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                S_ST: begin
                    ovf_clr = 1'b1;
                    state_d = S_DISCARD;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            asm_q   <= '0;
            tx_q    <= 8'h00;
            rd_ok_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            tx_q    <= tx_d;
            rd_ok_q <= rd_ok_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else if (hold_cap) begin
            hold_q      <= cpu_out_data;
            hold_full_q <= 1'b1;
        end else if (hold_rel) begin
            hold_full_q <= 1'b0;
        end
    end

    // With a simultaneous pop at full, wr_ptr equals the old rd_ptr, so the slot being vacated is reused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= 4'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= asm_shift;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + 4'd1;
            else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - 4'd1;
        end
    end

endmodule

// File: tb/tb_spi_cmd_bridge.sv
// Directed bench for spi_cmd_bridge with scoreboard queues for FIFO words and tx bytes.
module tb_spi_cmd_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_byte_ready;
    logic [7:0]  rx_byte;
    logic        cs_active;
    logic [7:0]  tx_byte;
    logic [15:0] cpu_in_data;
    logic        cpu_in_valid;
    logic        cpu_in_ready;
    logic [15:0] cpu_out_data;
    logic        cpu_out_valid;
    logic        cpu_out_ready;
    logic        overflow;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [15:0] exp_q [$];
    logic [7:0]  tx_q  [$];

    always #5 clk = ~clk;

    spi_cmd_bridge #(.DATA_W(16), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_byte_ready (rx_byte_ready),
        .rx_byte       (rx_byte),
        .cs_active     (cs_active),
        .tx_byte       (tx_byte),
        .cpu_in_data   (cpu_in_data),
        .cpu_in_valid  (cpu_in_valid),
        .cpu_in_ready  (cpu_in_ready),
        .cpu_out_data  (cpu_out_data),
        .cpu_out_valid (cpu_out_valid),
        .cpu_out_ready (cpu_out_ready),
        .overflow      (overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b, input logic [7:0] exp_tx);
        logic [7:0] e;
        @(negedge clk);
        rx_byte       = b;
        rx_byte_ready = 1'b1;
        tx_q.push_back(exp_tx);
        @(negedge clk);
        rx_byte_ready = 1'b0;
        e = tx_q.pop_front();
        check(tag, tx_byte, e);
    endtask

    task automatic send_word(input string tag, input logic [15:0] w, input bit stored);
        send_byte(tag, w[15:8], 8'h00);
        send_byte(tag, w[7:0], 8'h00);
        if (stored) exp_q.push_back(w);
    endtask

    task automatic frame_begin();
        @(negedge clk);
        cs_active = 1'b1;
    endtask

    task automatic frame_end();
        @(negedge clk);
        cs_active = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_check(input string tag);
        logic [15:0] e;
        int t;
        t = 0;
        @(negedge clk);
        while (!cpu_in_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        check({tag, ".vld"}, cpu_in_valid, 1);
        check(tag, cpu_in_data, e);
        cpu_in_ready = 1'b1;
        @(negedge clk);
        cpu_in_ready = 1'b0;
    endtask

    task automatic capture(input logic [15:0] w);
        @(negedge clk);
        cpu_out_data  = w;
        cpu_out_valid = 1'b1;
        @(negedge clk);
        cpu_out_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] e;
        rst_n         = 1'b0;
        rx_byte_ready = 1'b0;
        rx_byte       = 8'h00;
        cs_active     = 1'b0;
        cpu_in_ready  = 1'b0;
        cpu_out_data  = 16'h0000;
        cpu_out_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.tx", tx_byte, 8'h00);
        check("rst.in_vld", cpu_in_valid, 0);
        check("rst.in_dat", cpu_in_data, 16'h0000);
        check("rst.out_rdy", cpu_out_ready, 1);
        check("rst.ovf", overflow, 0);
        rst_n = 1'b1;

        // Single write word
        frame_begin();
        send_byte("wr1.cmd", 8'h01, 8'h00);
        send_byte("wr1.b0", 8'h12, 8'h00);
        check("wr1.vld_early", cpu_in_valid, 0);
        send_byte("wr1.b1", 8'h34, 8'h00);
        exp_q.push_back(16'h1234);
        check("wr1.vld", cpu_in_valid, 1);
        check("wr1.dat", cpu_in_data, 16'h1234);
        frame_end();
        frame_begin();
        send_byte("st1.cmd", 8'h03, 8'h01);
        send_byte("st1.b1", 8'h00, 8'h00);
        frame_end();
        pop_check("wr1.pop");
        check("wr1.empty", cpu_in_valid, 0);

        // Burst of 5 words into a 4-deep FIFO
        frame_begin();
        send_byte("burst.cmd", 8'h01, 8'h00);
        for (int i = 1; i <= 5; i++) send_word("burst.w", 16'(i), i <= 4);
        check("burst.ovf", overflow, 1);
        frame_end();
        frame_begin();
        send_byte("st2.cmd", 8'h03, 8'hA4);
        send_byte("st2.b1", 8'h00, 8'h00);
        send_byte("st2.b2", 8'h00, 8'h00);
        frame_end();
        check("st2.ovf_clr", overflow, 0);
        frame_begin();
        send_byte("st3.cmd", 8'h03, 8'h24);
        frame_end();
        for (int i = 0; i < 4; i++) pop_check("burst.pop");
        check("burst.empty", cpu_in_valid, 0);

        // Read-back of hold register
        capture(16'hBEEF);
        check("rd.rdy_full", cpu_out_ready, 0);
        frame_begin();
        send_byte("rd.cmd", 8'h02, 8'hBE);
        send_byte("rd.b1", 8'h5A, 8'hEF);
        check("rd.rdy_mid", cpu_out_ready, 0);
        send_byte("rd.b2", 8'hA5, 8'h00);
        check("rd.rdy_rel", cpu_out_ready, 1);
        send_byte("rd.b3", 8'h00, 8'h00);
        frame_end();
        frame_begin();
        send_byte("rd_empty.cmd", 8'h02, 8'h00);
        send_byte("rd_empty.b1", 8'h00, 8'h00);
        frame_end();

        // RD aborted mid-word keeps the hold register and restarts at byte 0
        capture(16'hCAFE);
        frame_begin();
        send_byte("rdab.cmd", 8'h02, 8'hCA);
        frame_end();
        check("rdab.rdy", cpu_out_ready, 0);
        frame_begin();
        send_byte("rdab2.cmd", 8'h02, 8'hCA);
        send_byte("rdab2.b1", 8'h00, 8'hFE);
        send_byte("rdab2.b2", 8'h00, 8'h00);
        frame_end();
        check("rdab2.rdy", cpu_out_ready, 1);

        // Partial word discarded on frame end
        frame_begin();
        send_byte("ab.cmd", 8'h01, 8'h00);
        send_byte("ab.b0", 8'hAA, 8'h00);
        frame_end();
        check("ab.no_push", cpu_in_valid, 0);
        frame_begin();
        send_byte("ab2.cmd", 8'h01, 8'h00);
        send_word("ab2.w", 16'h5566, 1'b1);
        frame_end();
        pop_check("ab2.pop");
        check("ab2.empty", cpu_in_valid, 0);

        // Unknown command
        frame_begin();
        send_byte("dis.cmd", 8'h7F, 8'h00);
        for (int i = 0; i < 3; i++) send_byte("dis.b", 8'h01, 8'h00);
        frame_end();
        check("dis.no_push", cpu_in_valid, 0);
        frame_begin();
        send_byte("st4.cmd", 8'h03, 8'h10);
        frame_end();

        // Push and pop in the same cycle while full
        frame_begin();
        send_byte("fp.cmd", 8'h01, 8'h00);
        for (int i = 1; i <= 4; i++) send_word("fp.w", 16'hA000 + 16'(i), 1'b1);
        send_byte("fp.hi", 8'hA0, 8'h00);
        @(negedge clk);
        e = exp_q.pop_front();
        check("fp.head", cpu_in_data, e);
        rx_byte       = 8'h05;
        rx_byte_ready = 1'b1;
        cpu_in_ready  = 1'b1;
        @(negedge clk);
        rx_byte_ready = 1'b0;
        cpu_in_ready  = 1'b0;
        exp_q.push_back(16'hA005);
        check("fp.ovf", overflow, 0);
        frame_end();
        frame_begin();
        send_byte("st5.cmd", 8'h03, 8'h24);
        frame_end();
        for (int i = 0; i < 4; i++) pop_check("fp.pop");

        // Asynchronous reset mid-write
        capture(16'h1111);
        frame_begin();
        send_byte("rst2.cmd", 8'h01, 8'h00);
        send_word("rst2.w", 16'h0102, 1'b0);
        send_word("rst2.w", 16'h0304, 1'b0);
        send_byte("rst2.part", 8'h77, 8'h00);
        check("rst2.pre_vld", cpu_in_valid, 1);
        check("rst2.pre_rdy", cpu_out_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst2.tx", tx_byte, 8'h00);
        check("rst2.in_vld", cpu_in_valid, 0);
        check("rst2.in_dat", cpu_in_data, 16'h0000);
        check("rst2.out_rdy", cpu_out_ready, 1);
        check("rst2.ovf", overflow, 0);
        cs_active = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        frame_begin();
        send_byte("st6.cmd", 8'h03, 8'h10);
        frame_end();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
